// File: rtl/tiny_synth_noise_pkg.sv
// Shared constants and types for the tiny_synth noise voice and its checker.
//   LFSR_LEN / FB_TAP : 23-bit noise LFSR, feedback = bit 22 XOR bit 17
//   OUT_TAPS          : LFSR bits that drive the 8 noise word MSBs, din[11:4]
//   TAP_DELAY         : valid-sample delay from each lower tap (din[10..4]) back
//                       to the MSB stream; equals 22 - tap index
//   state_e           : checker lock state
package tiny_synth_noise_pkg;

  localparam int LFSR_LEN     = 23;
  localparam int FB_TAP       = 17;
  localparam int N_OUT_TAPS   = 8;
  localparam int OUT_TAPS [N_OUT_TAPS] = '{22, 20, 16, 13, 11, 7, 4, 2};
  localparam int N_CHK_TAPS   = 7;
  localparam int TAP_DELAY [N_CHK_TAPS] = '{2, 6, 9, 11, 15, 18, 20};
  // Longest tap delay: lower-tap comparisons are meaningless before this many samples.
  localparam int TAP_FILL_MIN = 20;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Next MSB predicted from the MSB history h, where h[i] = m(n-1-i):
  // m(n) = m(n-23) ^ m(n-18).
  function automatic logic predict(input logic [LFSR_LEN-1:0] h);
    return h[LFSR_LEN-1] ^ h[FB_TAP];
  endfunction

endpackage

// File: rtl/tone_noise_checker_if.sv
// Noise sample bus between a noise source (master) and tone_noise_checker (slave).
//   din[11:0]   noise word, din_valid qualifier, clr_count synchronous count clear
//   locked, err, err_count  checker status returned to the master
interface tone_noise_checker_if #(
  parameter int ERR_W = 16
);
  logic [11:0]      din;
  logic             din_valid;
  logic             clr_count;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output din, din_valid, clr_count,
    input  locked, err, err_count
  );

  modport slave (
    input  din, din_valid, clr_count,
    output locked, err, err_count
  );
endinterface

// File: rtl/noise_tap_delay.sv
// Valid-gated 1-bit delay line: bit_out is the bit_in presented DEPTH valid
// samples ago (zero until that many valid samples have arrived).
//   clk, rst (async, active-high)
//   valid   : shift enable, one step per asserted cycle
//   bit_in  : bit to delay
//   bit_out : delayed bit
module noise_tap_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic bit_in,
  output logic bit_out
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    // NOTE: assign every comb output a default first so no path leaves it unassigned (no latch).
    sr_d = sr_q;
    if (valid) begin
      sr_d = (sr_q << 1) | DEPTH'(bit_in);
    end
  end

  // NOTE: the line is short, so it is reset with everything else; zeros match what
  // the comparison logic assumes before the line has filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      sr_q <= sr_d;
    end
  end

  assign bit_out = sr_q[DEPTH-1];

endmodule

// File: rtl/tone_noise_checker.sv
// Receive-side checker for the 23-bit noise LFSR voice. It learns the LFSR
// phase from the sample MSBs alone (HUNT -> VERIFY), then flywheels a local
// predictor (LOCKED) and flags samples that disagree with it.
//   clk, rst (async, active-high)
//   bus.din / bus.din_valid : noise word and qualifier
//   bus.clr_count           : synchronous clear of err_count, beats an increment
//   bus.locked              : in LOCKED
//   bus.err                 : one-cycle pulse, mismatch on a valid sample while LOCKED
//   bus.err_count           : saturating count of err pulses
// Outputs reflect valid sample n on the cycle after it is presented.
// Build option NOISE_CHECK_TAPS_EN: also cross-check din[10:4] against the
// MSB stream through per-tap delay lines.
module tone_noise_checker
  import tiny_synth_noise_pkg::*;
#(
  parameter int LOCK_COUNT = 16,
  parameter int MISS_LIMIT = 4,
  parameter int ERR_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  tone_noise_checker_if.slave bus
);

  localparam int FILL_W = $clog2(LFSR_LEN + 1);
  localparam int VER_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LFSR_LEN);

  state_e               state_q, state_d;
  logic [LFSR_LEN-1:0]  h_q, h_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [VER_W-1:0]     ver_q, ver_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic                 err_q, err_d;
  logic [ERR_W-1:0]     err_count_q, err_count_d;

  logic msb_rx;
  logic pred;
  logic tap_mismatch;
  logic mismatch;

  assign msb_rx = bus.din[11];
  assign pred   = predict(h_q);

`ifdef NOISE_CHECK_TAPS_EN
  // Lower tap din[10-i] equals the MSB that arrives TAP_DELAY[i] samples later,
  // so delaying each tap lines it up with the current MSB.
  logic [N_CHK_TAPS-1:0] tap_late;

  for (genvar i = 0; i < N_CHK_TAPS; i++) begin : g_tap
    noise_tap_delay #(
      .DEPTH (TAP_DELAY[i])
    ) u_dly (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.din_valid),
      .bit_in  (bus.din[10-i]),
      .bit_out (tap_late[i])
    );
  end

  assign tap_mismatch = (fill_q >= FILL_W'(TAP_FILL_MIN)) &&
                        (tap_late != {N_CHK_TAPS{msb_rx}});
`else
  logic unused_tap_bits;
  assign unused_tap_bits = ^bus.din[10:4];
  assign tap_mismatch    = 1'b0;
`endif

  assign mismatch = (msb_rx != pred) || (bus.din[3:0] != 4'h0) || tap_mismatch;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      h_q         <= '0;
      fill_q      <= '0;
      ver_q       <= '0;
      miss_q      <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      ver_q       <= ver_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    ver_d   = ver_q;
    miss_d  = miss_q;
    err_d   = 1'b0;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          h_d = {h_q[LFSR_LEN-2:0], msb_rx};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 1'b1;
          end
          // All-zero history is the LFSR lockup state; never try to verify it.
          if (fill_d == FILL_FULL && h_d != '0) begin
            state_d = VERIFY;
            ver_d   = '0;
          end
        end

        VERIFY: begin
          h_d   = {h_q[LFSR_LEN-2:0], msb_rx};
          ver_d = mismatch ? '0 : ver_q + 1'b1;
          if (h_d == '0) begin
            state_d = HUNT;
            fill_d  = '0;
          end else if (ver_d == VER_W'(LOCK_COUNT)) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end

        LOCKED: begin
          // Flywheel on the prediction so one bad MSB cannot poison later predictions.
          h_d = {h_q[LFSR_LEN-2:0], pred};
          if (mismatch) begin
            err_d  = 1'b1;
            miss_d = miss_q + 1'b1;
            if (miss_d == MISS_W'(MISS_LIMIT)) begin
              state_d = HUNT;
              fill_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: begin
          state_d = HUNT;
          fill_d  = '0;
        end
      endcase
    end

    err_count_d = err_count_q;
    if (bus.clr_count) begin
      err_count_d = '0;
    end else if (err_d && err_count_q != '1) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    bus.locked    = (state_q == LOCKED);
    bus.err       = err_q;
    bus.err_count = err_count_q;
  end

endmodule

// File: tb/tb_tone_noise_checker.sv
`timescale 1ns/1ps
module tb_tone_noise_checker;

  localparam int LOCK_COUNT = 16;
  localparam int MISS_LIMIT = 4;
  localparam logic [22:0] SEED = 23'h7FFFF8;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tone_noise_checker_if #(.ERR_W(16)) bus16 ();
  tone_noise_checker_if #(.ERR_W(4))  bus4 ();

  tone_noise_checker #(.LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT), .ERR_W(16)) dut16 (
    .clk (clk), .rst (rst), .bus (bus16)
  );
  tone_noise_checker #(.LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT), .ERR_W(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  int errors = 0;
  int checks = 0;

  // Noise generator: shift left, new bit0 = bit22 ^ bit17.
  logic [22:0] lfsr;

  function automatic logic [11:0] gen_word(input logic [22:0] s);
    return {s[22], s[20], s[16], s[13], s[11], s[7], s[4], s[2], 4'h0};
  endfunction

  function automatic logic [22:0] gen_next(input logic [22:0] s);
    return {s[21:0], s[22] ^ s[17]};
  endfunction

  // Reference model: last 23 history bits (oldest first), last 20 received words.
  int         m_state;
  bit         m_hist[$];
  logic [11:0] m_rx[$];
  int         m_fill, m_ver, m_miss;
  bit         m_err;
  int         m_cnt16, m_cnt4;
`ifdef NOISE_CHECK_TAPS_EN
  int lower_taps [7] = '{20, 16, 13, 11, 7, 4, 2};
`endif

  task automatic model_reset();
    m_hist.delete();
    m_rx.delete();
    for (int i = 0; i < 23; i++) m_hist.push_back(1'b0);
    for (int i = 0; i < 20; i++) m_rx.push_back(12'h000);
    m_state = M_HUNT;
    m_fill = 0; m_ver = 0; m_miss = 0;
    m_err = 0; m_cnt16 = 0; m_cnt4 = 0;
  endtask

  task automatic model_step(input logic [11:0] d, input bit v, input bit c);
    bit p, mis, nb, allz;
    m_err = 0;
    if (v) begin
      p   = m_hist[0] ^ m_hist[5];   // m(n-23) ^ m(n-18)
      mis = (d[11] != p) || (d[3:0] != 4'h0);
`ifdef NOISE_CHECK_TAPS_EN
      if (m_fill >= 20) begin
        for (int i = 0; i < 7; i++) begin
          logic [11:0] old;
          old = m_rx[20 - (22 - lower_taps[i])];
          if (old[10-i] != d[11]) mis = 1;
        end
      end
`endif
      nb = (m_state == M_LOCKED) ? p : d[11];
      void'(m_hist.pop_front());
      m_hist.push_back(nb);
      void'(m_rx.pop_front());
      m_rx.push_back(d);
      allz = 1;
      foreach (m_hist[i]) if (m_hist[i]) allz = 0;
      case (m_state)
        M_HUNT: begin
          if (m_fill < 23) m_fill++;
          if (m_fill == 23 && !allz) begin m_state = M_VERIFY; m_ver = 0; end
        end
        M_VERIFY: begin
          m_ver = mis ? 0 : m_ver + 1;
          if (allz) begin m_state = M_HUNT; m_fill = 0; end
          else if (m_ver == LOCK_COUNT) begin m_state = M_LOCKED; m_miss = 0; end
        end
        default: begin
          if (mis) begin
            m_err = 1;
            m_miss++;
            if (m_miss == MISS_LIMIT) begin m_state = M_HUNT; m_fill = 0; end
          end else begin
            m_miss = 0;
          end
        end
      endcase
    end
    if (c) begin
      m_cnt16 = 0; m_cnt4 = 0;
    end else if (m_err) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  function automatic logic [23:0] observed();
    return {bus16.locked, bus16.err, bus16.err_count, bus4.locked, bus4.err, bus4.err_count};
  endfunction

  function automatic logic [23:0] expected();
    logic l;
    logic [15:0] c16;
    logic [3:0]  c4;
    l   = (m_state == M_LOCKED);
    c16 = 16'(m_cnt16);
    c4  = 4'(m_cnt4);
    return {l, m_err, c16, l, m_err, c4};
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, sample #1 later.
  task automatic step(input logic [11:0] d, input bit v, input bit c);
    bus16.din = d; bus16.din_valid = v; bus16.clr_count = c;
    bus4.din  = d; bus4.din_valid  = v; bus4.clr_count  = c;
    @(posedge clk);
    model_step(d, v, c);
    #1;
    bus16.din_valid = 1'b0; bus16.clr_count = 1'b0;
    bus4.din_valid  = 1'b0; bus4.clr_count  = 1'b0;
  endtask

  task automatic gen_step(input bit c);
    step(gen_word(lfsr), 1'b1, c);
    lfsr = gen_next(lfsr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus16.din = '0; bus16.din_valid = 0; bus16.clr_count = 0;
    bus4.din  = '0; bus4.din_valid  = 0; bus4.clr_count  = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (observed() !== 24'h0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", observed(), 24'h0);
    end
    do_reset();
    checks++;
    if (observed() !== 24'h0) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", observed(), 24'h0);
    end
  endtask

  task automatic test_lock();
    do_reset();
    lfsr = SEED;
    for (int s = 1; s <= 1000; s++) begin
      gen_step(1'b0);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL lock_track s=%0d got=%h exp=%h", s, observed(), expected());
      end
      if (s == 38 || s == 39) begin
        checks++;
        if (bus16.locked !== (s == 39)) begin
          errors++;
          $display("FAIL lock_edge s=%0d locked=%b exp=%b", s, bus16.locked, (s == 39));
        end
      end
    end
    checks++;
    if (bus16.locked !== 1'b1 || bus16.err_count !== 16'd0) begin
      errors++;
      $display("FAIL lock_final locked=%b cnt=%0d exp locked=1 cnt=0", bus16.locked, bus16.err_count);
    end
  endtask

  task automatic test_single_flip();
    int k;
    k = $urandom_range(5, 30);
    for (int s = 0; s < k; s++) begin
      gen_step(1'b0);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL flip_pre s=%0d got=%h exp=%h", s, observed(), expected());
      end
    end
    step(gen_word(lfsr) ^ 12'h800, 1'b1, 1'b0);
    lfsr = gen_next(lfsr);
    checks++;
    if (bus16.err !== 1'b1 || bus16.err_count !== 16'd1 || bus16.locked !== 1'b1) begin
      errors++;
      $display("FAIL flip_hit err=%b cnt=%0d locked=%b exp err=1 cnt=1 locked=1",
               bus16.err, bus16.err_count, bus16.locked);
    end
    for (int s = 0; s < 100; s++) begin
      gen_step(1'b0);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL flip_post s=%0d got=%h exp=%h", s, observed(), expected());
      end
    end
    checks++;
    if (bus16.err_count !== 16'd1 || bus16.locked !== 1'b1) begin
      errors++;
      $display("FAIL flip_final cnt=%0d locked=%b exp cnt=1 locked=1", bus16.err_count, bus16.locked);
    end
  endtask

  task automatic test_loss_of_lock();
    bit found, z;
    logic [22:0] s;
    logic [11:0] w;
    gen_step(1'b1);  // clear the counter on a good sample
    found = 0;
    // Wait for a spot where the next four true MSBs are 0, so AB0 (MSB=1) must miss.
    for (int t = 0; t < 2000 && !found; t++) begin
      s = lfsr; z = 1;
      for (int j = 0; j < 4; j++) begin
        w = gen_word(s);
        if (w[11]) z = 0;
        s = gen_next(s);
      end
      if (z) found = 1;
      else begin
        gen_step(1'b0);
        checks++;
        if (observed() !== expected()) begin
          errors++;
          $display("FAIL loss_pre t=%0d got=%h exp=%h", t, observed(), expected());
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL loss_search found=0 exp=1");
    end
    if (found) begin
      for (int j = 1; j <= 4; j++) begin
        step(12'hAB0, 1'b1, 1'b0);
        lfsr = gen_next(lfsr);
        checks++;
        if (bus16.err !== 1'b1 || bus16.locked !== (j < 4) || bus16.err_count !== 16'(j)) begin
          errors++;
          $display("FAIL loss_burst j=%0d err=%b locked=%b cnt=%0d exp err=1 locked=%b cnt=%0d",
                   j, bus16.err, bus16.locked, bus16.err_count, (j < 4), j);
        end
      end
      for (int g = 1; g <= 39; g++) begin
        gen_step(1'b0);
        checks++;
        if (observed() !== expected()) begin
          errors++;
          $display("FAIL relock_track g=%0d got=%h exp=%h", g, observed(), expected());
        end
        if (g == 38 || g == 39) begin
          checks++;
          if (bus16.locked !== (g == 39)) begin
            errors++;
            $display("FAIL relock_edge g=%0d locked=%b exp=%b", g, bus16.locked, (g == 39));
          end
        end
      end
    end
  endtask

  task automatic test_valid_gaps();
    int nvalid;
    bit v;
    do_reset();
    lfsr = 23'($urandom) | 23'h1;
    nvalid = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      v = (cyc % 3 == 2);
      if (v) begin
        gen_step(1'b0);
        nvalid++;
      end else begin
        step(12'($urandom), 1'b0, 1'b0);
      end
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL gaps_track cyc=%0d got=%h exp=%h", cyc, observed(), expected());
      end
      if (v && (nvalid == 38 || nvalid == 39)) begin
        checks++;
        if (bus16.locked !== (nvalid == 39)) begin
          errors++;
          $display("FAIL gaps_lock n=%0d locked=%b exp=%b", nvalid, bus16.locked, (nvalid == 39));
        end
      end
      if (!v) begin
        checks++;
        if (bus16.err !== 1'b0) begin
          errors++;
          $display("FAIL gaps_idle_err cyc=%0d err=%b exp=0", cyc, bus16.err);
        end
      end
    end
  endtask

  task automatic test_low_nibble();
    step(12'h001, 1'b1, 1'b0);
    lfsr = gen_next(lfsr);
    checks++;
    if (bus16.err !== 1'b1 || bus16.locked !== 1'b1) begin
      errors++;
      $display("FAIL nibble_hit err=%b locked=%b exp err=1 locked=1", bus16.err, bus16.locked);
    end
    for (int s = 0; s < 30; s++) begin
      gen_step(1'b0);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL nibble_post s=%0d got=%h exp=%h", s, observed(), expected());
      end
    end
  endtask

  task automatic test_zero_stream();
    do_reset();
    for (int s = 0; s < 300; s++) begin
      step(12'h000, 1'b1, 1'b0);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL zero_track s=%0d got=%h exp=%h", s, observed(), expected());
      end
    end
    checks++;
    if (bus16.locked !== 1'b0 || bus16.err_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_final locked=%b cnt=%0d exp locked=0 cnt=0", bus16.locked, bus16.err_count);
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    lfsr = SEED;
    for (int s = 0; s < 39; s++) gen_step(1'b0);
    for (int f = 0; f < 20; f++) begin
      step(gen_word(lfsr) ^ 12'h800, 1'b1, 1'b0);
      lfsr = gen_next(lfsr);
      for (int g = 0; g < 3; g++) gen_step(1'b0);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL sat_track f=%0d got=%h exp=%h", f, observed(), expected());
      end
    end
    checks++;
    if (bus4.err_count !== 4'd15 || bus16.err_count !== 16'd20) begin
      errors++;
      $display("FAIL sat_hold cnt4=%0d cnt16=%0d exp cnt4=15 cnt16=20", bus4.err_count, bus16.err_count);
    end
    step(gen_word(lfsr) ^ 12'h800, 1'b1, 1'b1);
    lfsr = gen_next(lfsr);
    checks++;
    if (bus16.err !== 1'b1 || bus4.err_count !== 4'd0 || bus16.err_count !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority err=%b cnt4=%0d cnt16=%0d exp err=1 cnt4=0 cnt16=0",
               bus16.err, bus4.err_count, bus16.err_count);
    end
  endtask

  task automatic test_random();
    int burst;
    int r;
    bit v, c;
    logic [11:0] w;
    do_reset();
    lfsr = 23'($urandom) | 23'h1;
    burst = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 99) == 0);
      w = gen_word(lfsr);
      r = $urandom_range(0, 999);
      if (burst > 0) begin
        w = 12'($urandom);
        if (v) burst--;
      end else if (r < 5) begin
        burst = $urandom_range(3, 6);
      end else if (r < 25) begin
        w = w ^ 12'h800;
      end else if (r < 35) begin
        w[3:0] = 4'($urandom_range(1, 15));
      end else if (r < 45) begin
        w = w ^ (12'h010 << $urandom_range(0, 6));
      end
      step(w, v, c);
      if (v) lfsr = gen_next(lfsr);
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random_track cyc=%0d got=%h exp=%h", cyc, observed(), expected());
      end
    end
  endtask

  initial begin
    bus16.din = '0; bus16.din_valid = 0; bus16.clr_count = 0;
    bus4.din  = '0; bus4.din_valid  = 0; bus4.clr_count  = 0;
    model_reset();
    test_reset();
    test_lock();
    test_single_flip();
    test_loss_of_lock();
    test_valid_gaps();
    test_low_nibble();
    test_zero_stream();
    test_saturation_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
